// File: rtl/cmac_tx_arbiter.sv
// Packet-granular round-robin arbiter feeding the CMAC axis_tx port.
// Ports: tx_clk/sys_reset_in/link_up, src0_*/src1_* AXI-Stream sources,
// tx_out_* AXI-Stream sink, pkt_count0/1, drop_count, busy.
module cmac_tx_arbiter #(
  parameter int DATA_W = 512
) (
  input  logic                tx_clk,
  input  logic                sys_reset_in,
  input  logic                link_up,

  input  logic [DATA_W-1:0]   src0_tdata,
  input  logic [DATA_W/8-1:0] src0_tkeep,
  input  logic                src0_tlast,
  input  logic                src0_tuser,
  input  logic                src0_tvalid,
  output logic                src0_tready,

  input  logic [DATA_W-1:0]   src1_tdata,
  input  logic [DATA_W/8-1:0] src1_tkeep,
  input  logic                src1_tlast,
  input  logic                src1_tuser,
  input  logic                src1_tvalid,
  output logic                src1_tready,

  output logic [DATA_W-1:0]   tx_out_tdata,
  output logic [DATA_W/8-1:0] tx_out_tkeep,
  output logic                tx_out_tlast,
  output logic                tx_out_tuser,
  output logic                tx_out_tvalid,
  input  logic                tx_out_tready,

  output logic [31:0]         pkt_count0,
  output logic [31:0]         pkt_count1,
  output logic [31:0]         drop_count,
  output logic                busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PASS = 2'd1,
    DROP = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        grant_q, grant_d;
  logic        last_q, last_d;
  logic        busy_q;
  logic [31:0] cnt0_q, cnt0_d;
  logic [31:0] cnt1_q, cnt1_d;
  logic [31:0] drop_q, drop_d;

  logic sel_vld;
  logic sel_last;
  logic pick;
  logic rdy;
  logic vld;

  assign sel_vld  = grant_q ? src1_tvalid : src0_tvalid;
  assign sel_last = grant_q ? src1_tlast  : src0_tlast;

  // On a tie the source that did not win last time gets the grant.
  assign pick = (src0_tvalid & src1_tvalid) ? ~last_q : src1_tvalid;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt0_d  = cnt0_q;
    cnt1_d  = cnt1_q;
    drop_d  = drop_q;
    rdy     = 1'b0;
    vld     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (src0_tvalid | src1_tvalid) begin
          grant_d = pick;
          last_d  = pick;
          state_d = link_up ? PASS : DROP;
        end
      end
      PASS: begin
        vld = sel_vld;
        rdy = tx_out_tready;
        if (sel_vld & tx_out_tready & sel_last) begin
          if (grant_q) cnt1_d = cnt1_q + 32'd1;
          else         cnt0_d = cnt0_q + 32'd1;
          state_d = IDLE;
        end
      end
      DROP: begin
        rdy = 1'b1;
        if (sel_vld & sel_last) begin
          drop_d  = drop_q + 32'd1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge tx_clk) begin
    if (sys_reset_in) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
      busy_q  <= 1'b0;
      cnt0_q  <= '0;
      cnt1_q  <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      busy_q  <= (state_d != IDLE);
      cnt0_q  <= cnt0_d;
      cnt1_q  <= cnt1_d;
      drop_q  <= drop_d;
    end
  end

  // Handshakes are masked during reset so no beat moves while state clears.
  assign src0_tready   = rdy & ~grant_q & ~sys_reset_in;
  assign src1_tready   = rdy &  grant_q & ~sys_reset_in;
  assign tx_out_tvalid = vld & ~sys_reset_in;

  assign tx_out_tdata = grant_q ? src1_tdata : src0_tdata;
  assign tx_out_tkeep = grant_q ? src1_tkeep : src0_tkeep;
  assign tx_out_tlast = grant_q ? src1_tlast : src0_tlast;
  assign tx_out_tuser = grant_q ? src1_tuser : src0_tuser;

  assign pkt_count0 = cnt0_q;
  assign pkt_count1 = cnt1_q;
  assign drop_count = drop_q;
  assign busy       = busy_q;

endmodule
